// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the core data-bus to AXI4-Lite bridge.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WB,
        ST_RD_A,
        ST_RD_D,
        ST_DONE
    } dbus_state_e;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY:   err = 1'b0;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
            default:                          err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Store byte-lane steering, load alignment/extension and misalignment detection.
module lsu_align
    import cpu_bus_pkg::*;
(
    input  logic [2:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    output logic        misaligned_o,
    input  logic [2:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;

    always_comb begin
        misaligned_o = 1'b0;
        case (st_size_i)
            SIZE_B, SIZE_BU: misaligned_o = 1'b0;
            SIZE_H, SIZE_HU: misaligned_o = st_off_i[0];
            SIZE_W:          misaligned_o = (st_off_i != 2'b00);
            default:         misaligned_o = 1'b1;
        endcase
    end

    always_comb begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'b1111;
        case (st_size_i[1:0])
            2'b00: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_wstrb_o = 4'b0001 << st_off_i;
            end
            2'b01: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_wstrb_o = 4'b0011 << st_off_i;
            end
            default: begin
                st_wdata_o = st_data_i;
                st_wstrb_o = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_shifted = ld_raw_i >> {ld_off_i, 3'b000};
        ld_data_o  = ld_shifted;
        case (ld_size_i)
            SIZE_B:  ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            SIZE_H:  ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            SIZE_BU: ld_data_o = {24'h000000, ld_shifted[7:0]};
            SIZE_HU: ld_data_o = {16'h0000, ld_shifted[15:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/axi_lite_dbus_bridge.sv
// Single-beat core data port to AXI4-Lite master, stalling the pipeline via hold_o.
// Optional wait-state timeout is enabled by defining AXI_TIMEOUT_EN.
module axi_lite_dbus_bridge
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic              req_we_i,
    input  logic              req_re_i,
    input  logic [2:0]        req_size_i,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    output logic              err_o,
    output logic              hold_o,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    dbus_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       rdata_raw_q, rdata_raw_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              err_q, err_d;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic        misaligned;
    logic [31:0] ld_data;
    logic        timeout;

    lsu_align u_align (
        .st_size_i    (req_size_i),
        .st_off_i     (req_addr_i[1:0]),
        .st_data_i    (req_wdata_i),
        .st_wdata_o   (st_wdata),
        .st_wstrb_o   (st_wstrb),
        .misaligned_o (misaligned),
        .ld_size_i    (size_q),
        .ld_off_i     (addr_q[1:0]),
        .ld_raw_i     (rdata_raw_q),
        .ld_data_o    (ld_data)
    );

`ifdef AXI_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               in_wait;

    assign in_wait = (state_q == ST_WR) || (state_q == ST_WB) ||
                     (state_q == ST_RD_A) || (state_q == ST_RD_D);
    // Fires on the last of TIMEOUT_CYCLES cycles spent in one wait state.
    assign timeout = in_wait && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        timer_d = '0;
        if (in_wait && (state_d == state_q)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        size_d      = size_q;
        rdata_raw_d = rdata_raw_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_we_i || req_re_i) begin
                    addr_d      = req_addr_i;
                    size_d      = req_size_i;
                    rdata_raw_d = '0;
                    err_d       = misaligned;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    if (req_we_i) begin
                        wdata_d = st_wdata;
                        wstrb_d = st_wstrb;
                        state_d = misaligned ? ST_DONE : ST_WR;
                    end else begin
                        state_d = misaligned ? ST_DONE : ST_RD_A;
                    end
                end
            end
            ST_WR: begin
                aw_done_d = aw_done_q | m_awready;
                w_done_d  = w_done_q | m_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WB;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WB: begin
                if (m_bvalid) begin
                    err_d   = resp_is_err(m_bresp);
                    state_d = ST_DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_A: begin
                if (m_arready) begin
                    state_d = ST_RD_D;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_D: begin
                if (m_rvalid) begin
                    rdata_raw_d = m_rdata;
                    err_d       = resp_is_err(m_rresp);
                    state_d     = ST_DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            size_q      <= '0;
            rdata_raw_q <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            size_q      <= size_d;
            rdata_raw_q <= rdata_raw_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            err_q       <= err_d;
        end
    end

    // Handshake outputs derive from registered state only, so reset clears them at once.
    assign m_awvalid = (state_q == ST_WR) && !aw_done_q;
    assign m_wvalid  = (state_q == ST_WR) && !w_done_q;
    assign m_bready  = (state_q == ST_WB);
    assign m_arvalid = (state_q == ST_RD_A);
    assign m_rready  = (state_q == ST_RD_D);
    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_awprot  = 3'b000;
    assign m_arprot  = 3'b000;

    assign rvalid_o = (state_q == ST_DONE);
    assign err_o    = (state_q == ST_DONE) && err_q;
    assign rdata_o  = ((state_q == ST_DONE) && !err_q) ? ld_data : '0;
    assign hold_o   = ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                      ((state_q == ST_IDLE) && (req_we_i || req_re_i));

endmodule

// File: tb/tb_axi_lite_dbus_bridge.sv
// Directed self-checking bench for axi_lite_dbus_bridge with a configurable-latency AXI slave.
module tb_axi_lite_dbus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_we = 1'b0;
    logic        req_re = 1'b0;
    logic [2:0]  req_size = '0;
    logic [31:0] rdata_o;
    logic        rvalid_o, err_o, hold_o;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    int total = 0;
    int bad = 0;

    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic        r_en = 1'b1;
    logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
    logic [31:0] r_data = '0;

    always #5 clk = ~clk;

    axi_lite_dbus_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_we_i(req_we),
        .req_re_i(req_re), .req_size_i(req_size),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .err_o(err_o), .hold_o(hold_o),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // Slave: each ready rises after its valid has waited <delay> cycles; B/R answer immediately.
    always @(posedge clk) begin
        aw_wait <= (m_awvalid && !m_awready) ? aw_wait + 1 : 0;
        w_wait  <= (m_wvalid && !m_wready) ? w_wait + 1 : 0;
        ar_wait <= (m_arvalid && !m_arready) ? ar_wait + 1 : 0;
    end
    assign m_awready = m_awvalid && (aw_wait >= aw_delay);
    assign m_wready  = m_wvalid && (w_wait >= w_delay);
    assign m_arready = m_arvalid && (ar_wait >= ar_delay);
    assign m_bvalid  = m_bready;
    assign m_bresp   = b_resp;
    assign m_rvalid  = m_rready && r_en;
    assign m_rdata   = r_data;
    assign m_rresp   = r_resp;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Drives one request, holds it until rvalid_o, and records what the bus saw.
    task automatic run_req(input logic we, input logic re, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] data, input int bound,
                           output int lat, output int hold_n, output int aw_n, output int w_n,
                           output int ar_n, output logic err, output logic [31:0] rd,
                           output logic [31:0] aw_a, output logic [31:0] w_d,
                           output logic [3:0] w_s, output logic done);
        req_we = we; req_re = re; req_size = size; req_addr = addr; req_wdata = data;
        #1;
        lat = 0; hold_n = 0; aw_n = 0; w_n = 0; ar_n = 0;
        err = 1'b0; rd = '0; aw_a = '0; w_d = '0; w_s = '0; done = 1'b0;
        while (lat < bound) begin
            if (rvalid_o) begin
                done = 1'b1; err = err_o; rd = rdata_o;
                break;
            end
            if (hold_o) hold_n++;
            if (m_awvalid) begin aw_n++; aw_a = m_awaddr; end
            if (m_wvalid) begin w_n++; w_d = m_wdata; w_s = m_wstrb; end
            if (m_arvalid) ar_n++;
            tick();
            lat++;
        end
        req_we = 1'b0; req_re = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        total++;
        if ({hold_o, rvalid_o, err_o, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=00000000",
                     {hold_o, rvalid_o, err_o, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        end
        total++;
        if ({m_awaddr, m_araddr, m_wdata, rdata_o} !== 128'h0 || m_wstrb !== 4'h0) begin
            bad++;
            $display("FAIL reset_data awaddr=%h wdata=%h wstrb=%h rdata=%h exp=0",
                     m_awaddr, m_wdata, m_wstrb, rdata_o);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({hold_o, rvalid_o, m_awvalid, m_arvalid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release got=%b exp=0000", {hold_o, rvalid_o, m_awvalid, m_arvalid});
        end
    endtask

    task automatic test_stores;
        int lat, hn, awn, wn, arn;
        logic e, dn;
        logic [31:0] rd, aa, wd;
        logic [3:0] ws;
        run_req(1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'h1122_3344, 20,
                lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (aa !== 32'h1000_0004 || wd !== 32'h1122_3344 || ws !== 4'b1111) begin
            bad++;
            $display("FAIL sw_bus awaddr=%h wdata=%h wstrb=%b exp 10000004 11223344 1111", aa, wd, ws);
        end
        total++;
        if (!dn || lat != 3 || e !== 1'b0) begin
            bad++;
            $display("FAIL sw_latency done=%b lat=%0d err=%b exp 1 3 0", dn, lat, e);
        end
        total++;
        if (hn != 3) begin
            bad++;
            $display("FAIL sw_hold got=%0d exp=3", hn);
        end

        run_req(1'b1, 1'b0, 3'b000, 32'h1000_0003, 32'h0000_00AB, 20,
                lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (wd !== 32'hABAB_ABAB || ws !== 4'b1000 || aa !== 32'h1000_0003) begin
            bad++;
            $display("FAIL sb_steer awaddr=%h wdata=%h wstrb=%b exp 10000003 abababab 1000", aa, wd, ws);
        end

        run_req(1'b1, 1'b0, 3'b001, 32'h1000_0002, 32'h0000_1234, 20,
                lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (wd !== 32'h1234_1234 || ws !== 4'b1100) begin
            bad++;
            $display("FAIL sh_steer wdata=%h wstrb=%b exp 12341234 1100", wd, ws);
        end
    endtask

    task automatic test_split_handshake;
        int lat, hn, awn, wn, arn;
        logic e, dn;
        logic [31:0] rd, aa, wd;
        logic [3:0] ws;
        aw_delay = 3; w_delay = 0; b_resp = 2'b10;
        run_req(1'b1, 1'b0, 3'b010, 32'h4000_0008, 32'hDEAD_BEEF, 30,
                lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (awn != 4 || wn != 1) begin
            bad++;
            $display("FAIL aw_late_counts aw=%0d w=%0d exp 4 1", awn, wn);
        end
        total++;
        if (!dn || lat != 6 || e !== 1'b1) begin
            bad++;
            $display("FAIL aw_late_slverr done=%b lat=%0d err=%b exp 1 6 1", dn, lat, e);
        end
        aw_delay = 0; w_delay = 2; b_resp = 2'b00;
        run_req(1'b1, 1'b0, 3'b010, 32'h4000_000C, 32'h0BAD_F00D, 30,
                lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (awn != 1 || wn != 3 || !dn || lat != 5 || e !== 1'b0) begin
            bad++;
            $display("FAIL w_late aw=%0d w=%0d lat=%0d err=%b exp 1 3 5 0", awn, wn, lat, e);
        end
        w_delay = 0;
    endtask

    task automatic test_loads;
        int lat, hn, awn, wn, arn;
        logic e, dn;
        logic [31:0] rd, aa, wd;
        logic [3:0] ws;
        r_data = 32'h0000_8000;
        run_req(1'b0, 1'b1, 3'b000, 32'h1000_0001, 32'h0, 20, lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (!dn || lat != 3 || rd !== 32'hFFFF_FF80 || e !== 1'b0) begin
            bad++;
            $display("FAIL lb_sext lat=%0d rdata=%h err=%b exp 3 ffffff80 0", lat, rd, e);
        end
        r_data = 32'hBEEF_0000;
        run_req(1'b0, 1'b1, 3'b101, 32'h1000_0002, 32'h0, 20, lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (!dn || rd !== 32'h0000_BEEF) begin
            bad++;
            $display("FAIL lhu_zext rdata=%h exp 0000beef", rd);
        end
        r_data = 32'h7FFF_0000;
        run_req(1'b0, 1'b1, 3'b001, 32'h1000_0002, 32'h0, 20, lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (!dn || rd !== 32'h0000_7FFF) begin
            bad++;
            $display("FAIL lh_pos rdata=%h exp 00007fff", rd);
        end
        r_data = 32'h5555_AAAA; r_resp = 2'b11;
        run_req(1'b0, 1'b1, 3'b010, 32'h1000_0010, 32'h0, 20, lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (!dn || e !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL lw_decerr err=%b rdata=%h exp 1 00000000", e, rd);
        end
        r_resp = 2'b00;
    endtask

    task automatic test_misaligned;
        int lat, hn, awn, wn, arn;
        logic e, dn;
        logic [31:0] rd, aa, wd;
        logic [3:0] ws;
        r_data = 32'hFFFF_FFFF;
        run_req(1'b0, 1'b1, 3'b010, 32'h1000_0002, 32'h0, 20, lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (!dn || lat != 1 || arn != 0 || e !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL lw_misalign lat=%0d ar=%0d err=%b rdata=%h exp 1 0 1 0", lat, arn, e, rd);
        end
        run_req(1'b1, 1'b0, 3'b001, 32'h1000_0001, 32'h1234, 20, lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (!dn || lat != 1 || awn != 0 || wn != 0 || e !== 1'b1) begin
            bad++;
            $display("FAIL sh_misalign lat=%0d aw=%0d w=%0d err=%b exp 1 0 0 1", lat, awn, wn, e);
        end
        run_req(1'b0, 1'b1, 3'b011, 32'h1000_0000, 32'h0, 20, lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
        total++;
        if (!dn || lat != 1 || arn != 0 || e !== 1'b1) begin
            bad++;
            $display("FAIL bad_size lat=%0d ar=%0d err=%b exp 1 0 1", lat, arn, e);
        end
    endtask

    task automatic test_back_to_back;
        logic ok;
        r_data = 32'h1234_5678;
        req_re = 1'b1; req_size = 3'b010; req_addr = 32'h2000_0000;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rvalid_o) begin ok = 1'b1; break; end
            tick();
        end
        total++;
        if (!ok || rdata_o !== 32'h1234_5678) begin
            bad++;
            $display("FAIL b2b_first seen=%b rdata=%h exp 1 12345678", ok, rdata_o);
        end
        tick();
        total++;
        if ({rvalid_o, hold_o, m_arvalid} !== 3'b010) begin
            bad++;
            $display("FAIL b2b_bubble rvalid/hold/arvalid=%b exp 010", {rvalid_o, hold_o, m_arvalid});
        end
        tick();
        total++;
        if (m_arvalid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_ar arvalid=%b exp 1", m_arvalid);
        end
        r_data = 32'hCAFE_F00D; req_re = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rvalid_o) begin ok = 1'b1; break; end
            tick();
        end
        total++;
        if (!ok || rdata_o !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL b2b_second seen=%b rdata=%h exp 1 cafef00d", ok, rdata_o);
        end
        tick();
    endtask

    task automatic test_timeout;
        int lat, hn, awn, wn, arn;
        logic e, dn;
        logic [31:0] rd, aa, wd;
        logic [3:0] ws;
        ar_delay = 300; r_data = 32'h1111_1111;
        run_req(1'b0, 1'b1, 3'b010, 32'h5000_0000, 32'h0, 400, lat, hn, awn, wn, arn, e, rd, aa, wd, ws, dn);
`ifdef AXI_TIMEOUT_EN
        total++;
        if (!dn || lat != 256 || arn != 255 || e !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL ar_timeout done=%b lat=%0d ar=%0d err=%b rdata=%h exp 1 256 255 1 0",
                     dn, lat, arn, e, rd);
        end
`else
        total++;
        if (!dn || lat != 303 || arn != 301 || e !== 1'b0 || rd !== 32'h1111_1111) begin
            bad++;
            $display("FAIL ar_wait done=%b lat=%0d ar=%0d err=%b rdata=%h exp 1 303 301 0 11111111",
                     dn, lat, arn, e, rd);
        end
`endif
        ar_delay = 0;
    endtask

    task automatic test_reset_mid;
        logic saw;
        r_en = 1'b0;
        req_re = 1'b1; req_size = 3'b010; req_addr = 32'h3000_0000;
        tick();
        tick();
        total++;
        if ({m_rready, hold_o} !== 2'b11) begin
            bad++;
            $display("FAIL rd_d_reached rready/hold=%b exp 11", {m_rready, hold_o});
        end
        #1;
        rst = 1'b1; req_re = 1'b0;
        #1;
        total++;
        if ({m_rready, m_arvalid, m_awvalid, m_wvalid, m_bready, hold_o, rvalid_o, err_o} !== 8'h00 ||
            m_araddr !== 32'h0 || rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid ctl=%b araddr=%h rdata=%h exp 0",
                     {m_rready, m_arvalid, m_awvalid, m_wvalid, m_bready, hold_o, rvalid_o, err_o},
                     m_araddr, rdata_o);
        end
        tick();
        rst = 1'b0; r_en = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rvalid_o || m_rready) saw = 1'b1;
            tick();
        end
        total++;
        if (saw !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_pulse got=%b exp=0", saw);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        test_reset();
        test_stores();
        test_split_handshake();
        test_loads();
        test_misaligned();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_dbus_bridge.md
# axi_lite_dbus_bridge

Converts the core's single-beat data-memory port (address, write data, we/re, size, read data, hold) into an AXI4-Lite master. It sits directly downstream of the CPU top's RAM interface. It stalls the pipeline through the hold input while a transaction is outstanding. It performs byte-lane steering for stores and alignment plus sign/zero extension for loads.

## Interface
- ADDR_W, 32, address width
- TIMEOUT_CYCLES, 255, wait-cycle limit; used only with AXI_TIMEOUT_EN
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_addr_i  in  32  data address from EX
- req_wdata_i  in  32  store data, right-aligned
- req_we_i / req_re_i  in  1  store / load request
- req_size_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rdata_o  out  32  aligned, extended load result
- rvalid_o  out  1  one-cycle completion pulse for both loads and stores
- err_o  out  1  one-cycle pulse with rvalid_o on SLVERR/DECERR, misalignment, or timeout
- hold_o  out  1  pipeline stall request, to the CPU's hold_flag_i
- AXI master signals: m_awaddr/awprot(3'b000)/awvalid/awready, m_wdata/wstrb/wvalid/wready, m_bresp/bvalid/bready, m_araddr/arprot/arvalid/arready, m_rdata/rresp/rvalid/rready, all with standard widths

## Operation
- FSM states: IDLE, WR (AW/W outstanding), WB (wait B), RD_A (AR outstanding), RD_D (wait R), DONE.
- IDLE samples requests. If req_we_i, go to WR; we wins when we and re are both set. Otherwise, if req_re_i, go to RD_A. The address, data, size, strobe and byte offset are latched on entry.
- Misalignment: H with addr[0]=1, or W with addr[1:0]≠0. No AXI traffic is issued; go straight to DONE with err_o=1 and rdata_o=0.
- Invalid size codes (011, 110, 111) are handled the same as misalignment.
- WR: awvalid and wvalid rise together. Each drops independently on its own ready, tracked by aw_done and w_done flags. When both are done, go to WB.
- WB: bready=1. On bvalid, go to DONE; err = bresp[1].
- RD_A: arvalid=1 until arready, then go to RD_D. RD_D: rready=1. On rvalid, latch rdata and go to DONE; err = rresp[1].
- DONE: hold_o=0, rvalid_o=1. Inputs are ignored, since the request is still present this cycle. The next state is always IDLE.
- hold_o = (state∉{IDLE,DONE}) | (state==IDLE & (req_we_i|req_re_i)).
- Store steering:
  - B: wdata = {4{byte}}, wstrb = 1<<addr[1:0].
  - H: wdata = {2{half}}, wstrb = 0011<<addr[1:0].
  - W: wdata unchanged, wstrb = 1111.
- The address is sent unmodified, including the low bits.
- Load: shift m_rdata right by 8·addr[1:0], then sign-extend for B/H or zero-extend for BU/HU.

## Timing
- Reset values: state IDLE. All valid and ready outputs 0. hold_o=0, rvalid_o=0, err_o=0, rdata_o=0, AXI address/data/strobe 0.
- Reset mid-transaction drops all valids immediately. No completion pulse is produced.
- Minimum latency with zero-wait slaves:
  - Load: request cycle → RD_A (1) → RD_D (1) → DONE. rvalid_o arrives 3 cycles after the request is sampled.
  - Store: WR → WB → DONE, also 3 cycles.
- Back-to-back requests cost one bubble: a request can be accepted in IDLE only, never in DONE.
- Valids never drop before their ready, except on timeout.
- Ready arriving in the same cycle the valid rises completes that handshake in that cycle.
- AW and W readys in different cycles are both handled, in either order.

## Configuration
- AXI_TIMEOUT_EN defined:
  - A counter clears on entry to each wait state and increments every cycle spent in WR, WB, RD_A or RD_D.
  - At TIMEOUT_CYCLES, all valids and readys drop and the FSM goes to DONE with err_o=1 and rdata_o=0.
- AXI_TIMEOUT_EN undefined: no counter exists and the bridge waits indefinitely.

## Structure
- Package cpu_bus_pkg holds:
  - the dbus_state_e enum;
  - the SIZE_B/H/W/BU/HU localparams;
  - the AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR localparams.
- Combinational sub-module lsu_align computes the store wdata/wstrb, load extension, and misalignment flag. The FSM stays in the bridge.

## Test plan
- SW addr 0x1000_0004, data 0x1122_3344, zero-wait slave → awaddr 0x1000_0004, wdata 0x1122_3344, wstrb 1111; rvalid_o 3 cycles later with err_o=0; hold_o high for exactly 3 cycles.
- SB addr 0x1000_0003, data 0x0000_00AB → wdata 0xABAB_ABAB, wstrb 1000.
- LB addr 0x..01 with m_rdata 0x0000_8000 → rdata_o 0xFFFF_FF80. LHU addr 0x..02 with m_rdata 0xBEEF_0000 → 0x0000_BEEF.
- LW addr 0x..02 → no arvalid ever; the cycle after the request, rvalid_o=1, err_o=1, rdata_o=0.
- Store with wready immediate and awready after 3 cycles → wvalid for 1 cycle, awvalid for 4 cycles, then bready. bresp=2'b10 → err_o=1.
- Load with arready withheld for 300 cycles:
  - with AXI_TIMEOUT_EN, TIMEOUT_CYCLES=255 → arvalid drops, err_o=1;
  - without the macro → the bridge still waits.
  - Separately, assert rst while in RD_D → all outputs return to reset values in the same cycle.
